pipelined_imem_sync: RTL and testbench
======================================

Name: pipelined_imem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined MIPS CPU's IF stage. It replaces the fixed 32-word combinational ROM.
- Word-addressed RAM of 2**ADDR_W words with a loader write port, so testbenches and a boot loader can place programs.
- One-cycle registered fetch, with stall/flush control from the hazard unit and fetch-fault flags.
- A post-reset clear state machine zero-fills the array (zero is the NOP encoding) before fetches are accepted.

Parameters:
- ADDR_W, 5, word-index width; DEPTH = 2**ADDR_W words (default 32).
- NOP, 32'h00000000, word returned for bubbles, faults and flushes, and written during clear.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-high.
- Ld_We  in  1  loader write enable.
- Ld_Addr  in  ADDR_W  loader word index.
- Ld_Data  in  32  loader write data.
- Fetch_Req  in  1  IF stage requests the instruction at Addr.
- Stall  in  1  hold the registered outputs (load-use hazard).
- Flush  in  1  kill the fetched instruction (taken branch or jump).
- Addr  in  32  byte address (PC).
- Ready  out  1  array cleared; fetches and loads are accepted.
- Inst_Valid  out  1  Inst holds a fetched instruction.
- Inst  out  32  fetched instruction word.
- Inst_Addr  out  32  PC of the word in Inst.
- Fault  out  2  bit0 = misaligned (Addr[1:0] != 0); bit1 = out of range (Addr[31:ADDR_W+2] != 0).

Behaviour:
- Reset (Rst high at an edge):
  - state = CLEAR, clr_ptr = 0.
  - Ready = 0, Inst_Valid = 0, Inst = NOP, Inst_Addr = 0, Fault = 0.
  - Rst asserted mid-operation returns to CLEAR and the array is wiped again.
- CLEAR state:
  - Each edge writes NOP to mem[clr_ptr] and increments clr_ptr.
  - After the edge that writes word DEPTH-1, go to RUN; Ready = 1 from that edge onward.
  - Ready therefore rises exactly DEPTH edges after the first edge with Rst low.
  - Fetch_Req, Stall, Flush and Ld_We are ignored; outputs stay at their reset values.
- RUN state:
  - Ready = 1 and stays there until the next Rst.
- Loader:
  - Ld_We high at an edge writes mem[Ld_Addr] = Ld_Data, in every RUN cycle regardless of Stall or Flush.
- Fetch output update priority, evaluated each edge in RUN:
  1. Flush: Inst_Valid = 0, Inst = NOP, Fault = 0; Inst_Addr holds.
  2. Stall: all outputs hold.
  3. Fetch_Req: Inst_Valid = 1, Inst_Addr = Addr, Fault = {oor, mis}.
     - Inst = NOP if oor or mis is set.
     - Otherwise Inst = mem[Addr[ADDR_W+1:2]].
  4. Otherwise: Inst_Valid = 0, Inst = NOP, Fault = 0; Inst_Addr holds.
- Latency: data appears one edge after Fetch_Req is sampled. Back-to-back requests give one word per cycle.
- A faulted fetch still asserts Inst_Valid, so the pipeline can raise an exception.
- Same-edge load and fetch to the same word is read-before-write: the fetch returns the old word, and the new word is visible from the next fetch.
- Address wrap: none. Any address beyond the array is an out-of-range fault. It never aliases.
- Array storage has no reset other than the CLEAR sweep.

Test Plan:
- Reset then idle, ADDR_W=5: Ready stays 0 for 32 edges, then goes 1. Fetch of any address in 0x00..0x7C then returns 32'h00000000 with Inst_Valid=1 and Fault=0.
- Load words 1-3 with 2021000a, 20420006, 00435020, then fetch 0x04, 0x08, 0x0C back-to-back: Inst gives those words on consecutive cycles, and Inst_Addr follows 0x04, 0x08, 0x0C.
- Fetch 0x04, then hold Stall for 3 cycles while Addr changes to 0x08: Inst stays 2021000a with Inst_Addr 0x04. After Stall drops, Inst = 20420006 with Inst_Addr 0x08.
- Assert Flush together with Stall and Fetch_Req: Inst_Valid=0 and Inst=0 on the next cycle. Inst_Addr keeps its prior value.
- Fetch 0x06 gives Fault=01; fetch 0x80 gives Fault=10; fetch 0x82 gives Fault=11. Every faulted fetch returns Inst=0 with Inst_Valid=1.
- Write mem[2]=0xDEADBEEF and fetch 0x08 on the same edge: the result is 20420006. The next fetch of 0x08 returns DEADBEEF.
- Assert Rst mid-run: Ready drops and the CLEAR sweep repeats. Afterwards word 2 reads 0, and a Ld_We asserted during CLEAR leaves no effect.

Source files
------------

// File: rtl/pipelined_imem_sync.sv
// rtl/pipelined_imem_sync.sv - synchronous-read instruction memory with loader port, clear sweep and fetch control
module pipelined_imem_sync #(
    parameter int          ADDR_W = 5,
    parameter logic [31:0] NOP    = 32'h00000000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Ld_We,
    input  logic [ADDR_W-1:0] Ld_Addr,
    input  logic [31:0]       Ld_Data,
    input  logic              Fetch_Req,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [31:0]       Addr,
    output logic              Ready,
    output logic              Inst_Valid,
    output logic [31:0]       Inst,
    output logic [31:0]       Inst_Addr,
    output logic [1:0]        Fault
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_addr_q, inst_addr_d;
    logic [1:0]        fault_q, fault_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic              mis, oor;
    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       rd_word;

    assign mis       = |Addr[1:0];
    assign oor       = |Addr[31:ADDR_W+2];
    assign fetch_idx = Addr[ADDR_W+1:2];
    // Read sampled before this edge's write lands, giving read-before-write on collisions.
    assign rd_word   = mem[fetch_idx];

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        fault_d     = fault_q;
        mem_we      = 1'b0;
        mem_waddr   = Ld_Addr;
        mem_wdata   = Ld_Data;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = NOP;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we = Ld_We;
                if (Flush) begin
                    valid_d = 1'b0;
                    inst_d  = NOP;
                    fault_d = 2'b00;
                end else if (Stall) begin
                    valid_d = valid_q;
                end else if (Fetch_Req) begin
                    valid_d     = 1'b1;
                    inst_addr_d = Addr;
                    fault_d     = {oor, mis};
                    inst_d      = (oor || mis) ? NOP : rd_word;
                end else begin
                    valid_d = 1'b0;
                    inst_d  = NOP;
                    fault_d = 2'b00;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_CLEAR;
            clr_ptr_q   <= '0;
            valid_q     <= 1'b0;
            inst_q      <= NOP;
            inst_addr_q <= 32'h0;
            fault_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            fault_q     <= fault_d;
        end
    end

    // Array has no reset; the CLEAR sweep is its only initialisation.
    always_ff @(posedge Clk) begin
        if (mem_we && !Rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign Ready      = (state_q == S_RUN);
    assign Inst_Valid = valid_q;
    assign Inst       = inst_q;
    assign Inst_Addr  = inst_addr_q;
    assign Fault      = fault_q;
endmodule

// File: tb/tb_pipelined_imem_sync.sv
// tb/tb_pipelined_imem_sync.sv - scoreboard bench for pipelined_imem_sync
module tb_pipelined_imem_sync;
    logic        clk = 1'b0;
    logic        rst, ld_we, fetch_req, stall, flush;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data, addr;
    logic        ready, inst_valid;
    logic [31:0] inst, inst_addr;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    pipelined_imem_sync #(.ADDR_W(5), .NOP(32'h0)) dut (
        .Clk(clk), .Rst(rst), .Ld_We(ld_we), .Ld_Addr(ld_addr), .Ld_Data(ld_data),
        .Fetch_Req(fetch_req), .Stall(stall), .Flush(flush), .Addr(addr),
        .Ready(ready), .Inst_Valid(inst_valid), .Inst(inst), .Inst_Addr(inst_addr), .Fault(fault)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [67:0] sb[$];
    logic [67:0] e;

    logic [31:0] m [32];
    logic        m_run = 1'b0;
    int          m_ptr = 0;
    logic        m_v = 1'b0;
    logic [31:0] m_i = 32'h0, m_a = 32'h0;
    logic [1:0]  m_f = 2'b0;

    function automatic logic [67:0] observed();
        return {ready, inst_valid, inst, inst_addr, fault};
    endfunction

    task automatic step(input logic r, input logic we, input logic [4:0] la, input logic [31:0] ld,
                        input logic req, input logic stl, input logic fl, input logic [31:0] a);
        logic mis, oor;
        @(negedge clk);
        rst = r; ld_we = we; ld_addr = la; ld_data = ld;
        fetch_req = req; stall = stl; flush = fl; addr = a;
        mis = (a[1:0] != 2'b00);
        oor = (a[31:7] != 25'h0);
        if (r) begin
            m_run = 1'b0; m_ptr = 0; m_v = 1'b0; m_i = 32'h0; m_a = 32'h0; m_f = 2'b00;
        end else if (!m_run) begin
            m[m_ptr] = 32'h0;
            if (m_ptr == 31) m_run = 1'b1;
            m_ptr = (m_ptr + 1) % 32;
        end else begin
            if (fl) begin
                m_v = 1'b0; m_i = 32'h0; m_f = 2'b00;
            end else if (stl) begin
                m_v = m_v;
            end else if (req) begin
                m_v = 1'b1; m_a = a; m_f = {oor, mis};
                m_i = (oor || mis) ? 32'h0 : m[a[6:2]];
            end else begin
                m_v = 1'b0; m_i = 32'h0; m_f = 2'b00;
            end
            if (we) m[la] = ld;
        end
        sb.push_back({m_run, m_v, m_i, m_a, m_f});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL reset_state got=%h want=%h", observed(), e); end
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 32'h10);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL clear_sweep[%0d] got=%h want=%h", i, observed(), e); end
            n_cmp++;
            if (ready !== (i == 31)) begin n_fail++; $display("FAIL ready_rise[%0d] got=%b want=%b", i, ready, i == 31); end
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 32'(i * 4));
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL zero_fetch[%0d] got=%h want=%h", i, observed(), e); end
            n_cmp++;
            if ({inst_valid, inst, fault} !== {1'b1, 32'h0, 2'b00}) begin
                n_fail++; $display("FAIL zero_word[%0d] got=%b/%h/%b want=1/0/00", i, inst_valid, inst, fault);
            end
        end
    endtask

    task automatic test_load_fetch();
        logic [31:0] words [3];
        words = '{32'h2021000a, 32'h20420006, 32'h00435020};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'(i + 1), words[i], 0, 0, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL load[%0d] got=%h want=%h", i, observed(), e); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 32'((i + 1) * 4));
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL b2b_fetch[%0d] got=%h want=%h", i, observed(), e); end
            n_cmp++;
            if ({inst, inst_addr} !== {words[i], 32'((i + 1) * 4)}) begin
                n_fail++; $display("FAIL b2b_word[%0d] got=%h@%h want=%h@%h", i, inst, inst_addr, words[i], (i + 1) * 4);
            end
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 1, 0, 0, 32'h04);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e) begin n_fail++; $display("FAIL stall_pre got=%h want=%h", observed(), e); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 1, 0, 32'h08);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, observed(), e); end
            n_cmp++;
            if ({inst_valid, inst, inst_addr} !== {1'b1, 32'h2021000a, 32'h04}) begin
                n_fail++; $display("FAIL stall_word[%0d] got=%h@%h want=2021000a@4", i, inst, inst_addr);
            end
        end
        step(0, 0, 0, 0, 1, 0, 0, 32'h08);
        e = sb.pop_front(); n_cmp++;
        if ({inst, inst_addr} !== {32'h20420006, 32'h08} || observed() !== e) begin
            n_fail++; $display("FAIL stall_release got=%h want=%h", observed(), e);
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 0, 1, 1, 1, 32'h0C);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e) begin n_fail++; $display("FAIL flush got=%h want=%h", observed(), e); end
        n_cmp++;
        if ({inst_valid, inst, inst_addr} !== {1'b0, 32'h0, 32'h08}) begin
            n_fail++; $display("FAIL flush_out got=%b/%h/%h want=0/0/8", inst_valid, inst, inst_addr);
        end
    endtask

    task automatic test_fault();
        logic [31:0] fa [3];
        logic [1:0]  fe [3];
        fa = '{32'h06, 32'h80, 32'h82};
        fe = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, fa[i]);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL fault_sb[%0d] got=%h want=%h", i, observed(), e); end
            n_cmp++;
            if ({inst_valid, inst, fault} !== {1'b1, 32'h0, fe[i]}) begin
                n_fail++; $display("FAIL fault_bits[%0d] got=%b/%h/%b want=1/0/%b", i, inst_valid, inst, fault, fe[i]);
            end
        end
    endtask

    task automatic test_read_before_write();
        step(0, 1, 5'd2, 32'hDEADBEEF, 1, 0, 0, 32'h08);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e || inst !== 32'h20420006) begin
            n_fail++; $display("FAIL rbw_old got=%h want=%h", observed(), e);
        end
        step(0, 0, 0, 0, 1, 0, 0, 32'h08);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e || inst !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rbw_new got=%h want=%h", observed(), e);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 0, 0, 0, 1, 0, 0, 32'h08);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e || ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%h want=%h", observed(), e); end
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 5'd2, 32'hFFFF_FFFF, 1, 0, 0, 32'h08);
            e = sb.pop_front(); n_cmp++;
            if (observed() !== e) begin n_fail++; $display("FAIL reclear[%0d] got=%h want=%h", i, observed(), e); end
        end
        step(0, 0, 0, 0, 1, 0, 0, 32'h08);
        e = sb.pop_front(); n_cmp++;
        if (observed() !== e || {inst_valid, inst} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wiped_word got=%h want=%h", observed(), e);
        end
    endtask

    initial begin
        rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        fetch_req = 1'b0; stall = 1'b0; flush = 1'b0; addr = '0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        test_reset();
        test_load_fetch();
        test_stall();
        test_flush();
        test_fault();
        test_read_before_write();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
